seven_seg_scanner: RTL and testbench

- Time-multiplexed digit scanner feeding HexTo7SegmentDecoder. It sits upstream of the decoder.
- Takes a packed multi-digit hex value and per-digit decimal-point mask. Presents one digit per refresh slot as hex/dp to the decoder, and drives the active-low common-anode selects.
- A shadow/active register pair prevents tearing when the value changes mid-frame.

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seven_seg_refresh_tick.sv | 25 ++
 rtl/seven_seg_scanner.sv | 111 +++++++++++
 tb/tb_seven_seg_scanner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and anode-select helper for scanned seven-segment displays
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;
  localparam logic                  DP_OFF    = 1'b1;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [MAX_DIGITS-1:0] digit_sel(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_refresh_tick.sv
// rtl/seven_seg_refresh_tick.sv - free-running 0..REFRESH_DIV-1 counter; tick is high on the wrap cycle
module seven_seg_refresh_tick #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed digit scanner with shadow/active frame buffering
// Optional leading-zero anode blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  input  logic                  blank,
  output logic [3:0]            hex,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int                IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_OFF = DIGIT_OFF[DIGITS-1:0];

  logic                tick;
  logic                wrap;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [4*DIGITS-1:0] active_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   active_dp;
  logic                pending;
  logic                slot_first;

  logic [3:0]          hex_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;
  logic                suppress;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic                zero_above;
`endif

  seven_seg_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap = tick && (idx == IDX_W'(DIGITS - 1));

  always_comb begin
    suppress = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Digit i is dark when it and every digit above it hold zero and it has no DP.
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (active_val[4*i +: 4] == 4'd0);
      if ((idx == IDX_W'(i)) && zero_above && !active_dp[i]) begin
        suppress = 1'b1;
      end
    end
`endif
    hex_nxt = active_val[4*idx +: 4];
    dp_nxt  = ~active_dp[idx];
    an_nxt  = DIGITS'(digit_sel(3'(idx)));
    if (blank || suppress) begin
      an_nxt = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      active_val  <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
      slot_first  <= 1'b1;
      hex         <= 4'd0;
      dp          <= DP_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      slot_first <= tick;
      if (tick) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      // A load on the swap tick still lands in shadow and keeps pending set.
      if (wrap && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_mask;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending    <= 1'b0;
      end
      hex         <= hex_nxt;
      dp          <= dp_nxt;
      an          <= an_nxt;
      frame_start <= slot_first && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - randomized self-checking bench for seven_seg_scanner
// Expectations follow SEVEN_SEG_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seven_seg_scanner;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int CNT_W       = $clog2(REFRESH_DIV);
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        load;
  logic        blank;
  logic [3:0]  hex;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_mask     (dp_mask),
    .load        (load),
    .blank       (blank),
    .hex         (hex),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference: k counts cycles since reset release; each frame shows the data latched at its boundary.
  bit          running = 1'b0;
  int          k = 0;
  logic [15:0] m_shadow_v = '0;
  logic [3:0]  m_shadow_dp = '0;
  logic [15:0] m_shown_v = '0;
  logic [3:0]  m_shown_dp = '0;
  bit          m_pending = 1'b0;
  logic [3:0]  e_hex;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t (k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  function automatic int next_k();
    return running ? k + 1 : 0;
  endfunction

  function automatic bit leading_dark(input int d);
    if (d == 0) return 1'b0;
    for (int j = d; j < DIGITS; j++) begin
      if (((m_shown_v >> (4 * j)) & 16'hF) != 16'h0) return 1'b0;
    end
    return !m_shown_dp[d];
  endfunction

  task automatic model_edge();
    int d;
    if (rst) begin
      running     = 1'b0;
      m_shadow_v  = '0;
      m_shadow_dp = '0;
      m_shown_v   = '0;
      m_shown_dp  = '0;
      m_pending   = 1'b0;
      e_an        = 4'hF;
      e_hex       = 4'h0;
      e_dp        = 1'b1;
      e_fs        = 1'b0;
    end else begin
      k       = next_k();
      running = 1'b1;
      d       = (k / REFRESH_DIV) % DIGITS;
      e_hex   = 4'((m_shown_v >> (4 * d)) & 16'hF);
      e_dp    = !m_shown_dp[d];
      e_fs    = (k % FRAME) == 0;
      e_an    = blank ? 4'hF : ~(4'b0001 << d);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (leading_dark(d)) e_an = 4'hF;
`endif
      if ((k % FRAME) == FRAME - 1 && m_pending) begin
        m_shown_v  = m_shadow_v;
        m_shown_dp = m_shadow_dp;
        m_pending  = 1'b0;
      end
      if (load) begin
        m_shadow_v  = value;
        m_shadow_dp = dp_mask;
        m_pending   = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit b, input logic [15:0] v, input logic [3:0] m);
    rst = r; load = l; blank = b; value = v; dp_mask = m;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("hex", 32'(hex), 32'(e_hex));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Runs idle cycles until the next edge lands on the given position within a frame.
  task automatic seek(input int pos);
    for (int i = 0; i < FRAME && (next_k() % FRAME) != pos; i++) idle(1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp_mask = '0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    idle(2 * FRAME + 4);

    seek(2 * REFRESH_DIV + 1);
    cyc(1'b0, 1'b1, 1'b0, 16'hA3F1, 4'b0100);
    idle(2 * FRAME + 2);

    seek(5);
    cyc(1'b0, 1'b1, 1'b0, 16'h1234, 4'b0000);
    seek(FRAME - 1);
    cyc(1'b0, 1'b1, 1'b0, 16'h5678, 4'b0010);
    idle(2 * FRAME + 2);

    seek(REFRESH_DIV + 1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
    idle(FRAME + 4);

    seek(3 * REFRESH_DIV + 1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    idle(FRAME + 4);

    cyc(1'b0, 1'b1, 1'b0, 16'h0040, 4'b0000);
    idle(2 * FRAME + 2);
    cyc(1'b0, 1'b1, 1'b0, 16'h0040, 4'b0100);
    idle(2 * FRAME + 2);

    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 9) == 0),
          16'($urandom),
          4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
